// File: rtl/add_round_key.sv
// PRESENT-80 AddRoundKey stage: XORs the cipher state with the current round key
// and advances the key schedule on each accepted block.
module add_round_key #(
    parameter int SIZE     = 64,
    parameter int KEY_SIZE = 80,
    parameter int ROUNDS   = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                key_load,
    input  logic [KEY_SIZE-1:0] key_in,
    input  logic                in_valid,
    input  logic [SIZE-1:0]     in_data,
    output logic                in_ready,
    output logic                out_valid,
    output logic [SIZE-1:0]     out_data,
    input  logic                out_ready,
    output logic [4:0]          out_round,
    output logic                out_last,
    output logic                busy
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    localparam logic [5:0] LAST_ROUND = 6'(ROUNDS);

    logic [1:0]          state;
    logic [KEY_SIZE-1:0] key_reg;
    logic [KEY_SIZE-1:0] key_next;
    logic [5:0]          round_ctr;
    logic                accept;
    logic                last_round;

    function automatic logic [3:0] sbox(input logic [3:0] x);
        case (x)
            4'h0: sbox = 4'hC;
            4'h1: sbox = 4'h5;
            4'h2: sbox = 4'h6;
            4'h3: sbox = 4'hB;
            4'h4: sbox = 4'h9;
            4'h5: sbox = 4'h0;
            4'h6: sbox = 4'hA;
            4'h7: sbox = 4'hD;
            4'h8: sbox = 4'h3;
            4'h9: sbox = 4'hE;
            4'hA: sbox = 4'hF;
            4'hB: sbox = 4'h8;
            4'hC: sbox = 4'h4;
            4'hD: sbox = 4'h7;
            4'hE: sbox = 4'h1;
            default: sbox = 4'h2;
        endcase
    endfunction

    assign in_ready   = (state == RUN) && (!out_valid || out_ready);
    assign accept     = in_valid && in_ready;
    assign busy       = (state != IDLE);
    assign last_round = (round_ctr == LAST_ROUND);

    // Key schedule step: rotate left by 61, S-box the top nibble, mix in the round counter.
    always_comb begin
        // NOTE: combinational blocks use blocking '=' and assign every output first, so no latch is inferred.
        key_next          = {key_reg[18:0], key_reg[KEY_SIZE-1:19]};
        key_next[79:76]   = sbox(key_next[79:76]);
        key_next[19:15]   = key_next[19:15] ^ round_ctr[4:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            key_reg   <= '0;
            round_ctr <= 6'd1;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_round <= '0;
            out_data  <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking '<=' so every register sees pre-edge values.
            case (state)
                IDLE: begin
                    if (key_load) begin
                        key_reg   <= key_in;
                        round_ctr <= 6'd1;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    if (accept) begin
                        if (last_round) begin
                            state <= DRAIN;
                        end else begin
                            key_reg   <= key_next;
                            round_ctr <= round_ctr + 6'd1;
                        end
                    end
                end
                DRAIN: begin
                    if (!out_valid || out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase

            // One-deep output register: reload on accept, otherwise empty on handshake.
            if (accept) begin
                out_valid <= 1'b1;
                out_data  <= in_data ^ key_reg[KEY_SIZE-1:KEY_SIZE-SIZE];
                out_round <= round_ctr[4:0];
                out_last  <= last_round;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_add_round_key.sv
// Randomized self-checking bench for add_round_key against a PRESENT-80 round-key
// and sLayer/pLayer reference model with an expected-output queue.
module tb_add_round_key;

    logic        clk = 1'b0;
    logic        rst;
    logic        key_load;
    logic [79:0] key_in;
    logic        in_valid;
    logic [63:0] in_data;
    logic        in_ready;
    logic        out_valid;
    logic [63:0] out_data;
    logic        out_ready;
    logic [4:0]  out_round;
    logic        out_last;
    logic        busy;

    always #5 clk = ~clk;

    add_round_key dut (
        .clk       (clk),
        .rst       (rst),
        .key_load  (key_load),
        .key_in    (key_in),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .out_round (out_round),
        .out_last  (out_last),
        .busy      (busy)
    );

    typedef struct packed {
        logic [63:0] data;
        logic [4:0]  round;
        logic        last;
    } exp_t;

    localparam logic [3:0] SBOX [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                                        4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};

    exp_t        exp_q[$];
    int          checks   = 0;
    int          failures = 0;
    logic [63:0] rk  [1:32];
    logic [63:0] obs [0:31];
    bit          prev_stall = 1'b0;
    exp_t        held;

    task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] s_layer(input logic [63:0] x);
        logic [63:0] y = '0;
        for (int i = 0; i < 16; i++) y[i*4 +: 4] = SBOX[x[i*4 +: 4]];
        return y;
    endfunction

    function automatic logic [63:0] p_layer(input logic [63:0] x);
        logic [63:0] y = '0;
        for (int i = 0; i < 63; i++) y[(i * 16) % 63] = x[i];
        y[63] = x[63];
        return y;
    endfunction

    task automatic make_keys(input logic [79:0] key);
        logic [79:0] k = key;
        for (int r = 1; r <= 32; r++) begin
            rk[r] = k[79:16];
            k = (k << 61) | (k >> 19);
            k[79:76] = SBOX[k[79:76]];
            k[19:15] = k[19:15] ^ 5'(r);
        end
    endtask

    // Output monitor: every handshake must match the oldest expected entry; stalls must hold.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_valid", 80'(out_valid), 80'(1));
                check("hold_outputs", 80'({out_data, out_round, out_last}), 80'(held));
            end
            if (out_valid && out_ready) begin
                obs[out_round] = out_data;
                if (exp_q.size() == 0) begin
                    check("spurious_out", 80'(1), 80'(0));
                end else begin
                    e = exp_q.pop_front();
                    check("out_data", 80'(out_data), 80'(e.data));
                    check("out_round", 80'(out_round), 80'(e.round));
                    check("out_last", 80'(out_last), 80'(e.last));
                end
            end
            prev_stall = out_valid && !out_ready;
            held       = '{out_data, out_round, out_last};
        end
    end

    // mode: 0 = all-zero data, 1 = chained through sLayer/pLayer from pt, 2 = random data
    task automatic stream(input logic [79:0] key, input int mode, input logic [63:0] pt,
                          input bit rnd, input int stall_at, input int inject_at, input int abort_at);
        int          idx      = 1;
        int          budget   = 0;
        int          n        = 0;
        bit          stalled  = 1'b0;
        bit          acc_prev = 1'b0;
        logic [63:0] data;
        logic [63:0] res;

        make_keys(key);
        key_load = 1'b1;
        key_in   = key;
        @(posedge clk); #1;
        key_load = 1'b0;
        data = (mode == 1) ? pt : (mode == 0) ? 64'h0 : {$urandom, $urandom};

        while (idx <= 32 && budget < 2000) begin
            if (idx == stall_at && !stalled) begin
                stalled   = 1'b1;
                out_ready = 1'b0;
                in_valid  = 1'b1;
                in_data   = data;
                repeat (5) begin
                    @(negedge clk);
                    check("stall_in_ready", 80'(in_ready), 80'(0));
                    @(posedge clk); #1;
                end
            end
            out_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            in_valid  = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            in_data   = data;
            key_load  = (idx == inject_at);
            key_in    = (idx == inject_at) ? ~key : key;
            @(negedge clk);
            if (acc_prev) check("latency_valid", 80'(out_valid), 80'(1));
            acc_prev = 1'b0;
            if (in_valid && in_ready) begin
                res = data ^ rk[idx];
                exp_q.push_back('{res, 5'(idx), idx == 32});
                data = (mode == 1) ? p_layer(s_layer(res)) :
                       (mode == 0) ? 64'h0 : {$urandom, $urandom};
                idx++;
                acc_prev = 1'b1;
            end
            @(posedge clk); #1;
            key_load = 1'b0;
            if (abort_at != 0 && idx == abort_at + 1) begin
                check("pre_abort_valid", 80'(out_valid), 80'(1));
                rst       = 1'b1;
                in_valid  = 1'b0;
                out_ready = 1'b0;
                @(posedge clk); #1;
                rst = 1'b0;
                exp_q.delete();
                @(negedge clk);
                check("abort_out_valid", 80'(out_valid), 80'(0));
                check("abort_busy", 80'(busy), 80'(0));
                check("abort_in_ready", 80'(in_ready), 80'(0));
                @(posedge clk); #1;
                return;
            end
            budget++;
        end
        if (idx <= 32) check("stream_timeout", 80'(idx), 80'(33));

        in_valid  = 1'b0;
        out_ready = 1'b1;
        while ((busy || exp_q.size() != 0) && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain_idle", 80'(busy), 80'(0));
        check("drain_empty", 80'(exp_q.size()), 80'(0));
        @(negedge clk);
        check("idle_in_ready", 80'(in_ready), 80'(0));
        check("idle_out_valid", 80'(out_valid), 80'(0));
        @(posedge clk); #1;
    endtask

    initial begin
        rst       = 1'b1;
        key_load  = 1'b0;
        key_in    = '0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready", 80'(in_ready), 80'(0));
        check("rst_busy", 80'(busy), 80'(0));
        check("rst_out_valid", 80'(out_valid), 80'(0));
        check("rst_out_data", 80'(out_data), 80'(0));
        check("rst_out_round", 80'(out_round), 80'(0));
        check("rst_out_last", 80'(out_last), 80'(0));
        @(posedge clk); #1;

        // in_valid is ignored while idle
        in_valid = 1'b1;
        in_data  = {$urandom, $urandom};
        repeat (3) begin
            @(negedge clk);
            check("idle_ignore_in_ready", 80'(in_ready), 80'(0));
            @(posedge clk); #1;
        end
        in_valid = 1'b0;

        stream(80'h0, 0, 64'h0, 1'b0, 0, 0, 0);
        check("zero_round1", 80'(obs[1]), 80'(64'h0000000000000000));
        check("zero_round2", 80'(obs[2]), 80'(64'hC000000000000000));

        stream(80'h0, 1, 64'h0, 1'b0, 0, 0, 0);
        check("cipher_key0_pt0", 80'(obs[0]), 80'(64'h5579C1387B228445));

        stream({$urandom, $urandom, $urandom}, 1, {$urandom, $urandom}, 1'b0, 6, 0, 0);
        stream({$urandom, $urandom, 16'h1234}, 2, 64'h0, 1'b1, 0, 7, 0);
        stream({$urandom, $urandom, $urandom}, 2, 64'h0, 1'b0, 0, 0, 10);
        stream({$urandom, $urandom, $urandom}, 2, 64'h0, 1'b1, 0, 0, 0);
        for (int t = 0; t < 3; t++)
            stream({$urandom, $urandom, $urandom}, 1, {$urandom, $urandom}, 1'b1, 0, 3 + t, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/add_round_key.md
ADD_ROUND_KEY -- requirements
Module: add_round_key

Parameters
REQ-001 SIZE, 64, state width in bits; only 64 is supported.
REQ-002 KEY_SIZE, 80, key width in bits (PRESENT-80 schedule).
REQ-003 ROUNDS, 32, number of round keys produced per key load (31 rounds plus final whitening).

Interface
REQ-004 clk  in  1  single clock; all state updates on the rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 key_load  in  1  pulse; loads key_in when FSM is IDLE.
REQ-007 key_in  in  80  cipher key, bit 79 MSB.
REQ-008 in_valid  in  1  in_data valid.
REQ-009 in_data  in  64  cipher state entering the round.
REQ-010 in_ready  out  1  block accepts in_data this cycle.
REQ-011 out_valid  out  1  out_data valid.
REQ-012 out_data  out  64  in_data XOR current round key; feeds the substitution layer.
REQ-013 out_ready  in  1  downstream accepts out_data.
REQ-014 out_round  out  5  round index of out_data, 1..31; 0 encodes round 32 (whitening).
REQ-015 out_last  out  1  out_data is the round-32 whitening result (ciphertext).
REQ-016 busy  out  1  FSM not IDLE.

Function
REQ-017 Internal state: key_reg[79:0], round_ctr[5:0] (1..32), one-entry output register, FSM {IDLE, RUN, DRAIN}.
REQ-018 Round key K_i = key_reg[79:16] while round_ctr = i.
REQ-019 IDLE: in_ready = 0; key_load = 1 -> key_reg <= key_in, round_ctr <= 1, next state RUN.
REQ-020 key_load while RUN or DRAIN is ignored; key_reg and round_ctr are unaffected.
REQ-021 RUN: in_ready = !out_valid || out_ready; the output register is one-deep and takes full-throughput back-to-back transfers.
REQ-022 An accept (in_valid && in_ready) loads out_data <= in_data ^ key_reg[79:16], out_round <= round_ctr[4:0], out_last <= (round_ctr == 32), and sets out_valid next cycle; latency is 1 cycle.
REQ-023 On an accept with round_ctr <= 31, the key update uses the pre-increment counter: key_reg <= rotl(key_reg, 61); then [79:76] <= SBOX([79:76]); then [19:15] ^= round_ctr[4:0]; round_ctr increments.
REQ-024 SBOX is the PRESENT 4-bit S-box: 0..F -> C,5,6,B,9,0,A,D,3,E,F,8,4,7,1,2.
REQ-025 An accept at round_ctr = 32 moves the FSM to DRAIN; key_reg is not updated.
REQ-026 DRAIN: in_ready = 0; when out_valid && out_ready, or out_valid = 0, the FSM goes to IDLE.
REQ-027 out_valid clears on out_ready when no new accept occurs in the same cycle; an accept and a drain in the same cycle reload the register with no bubble.
REQ-028 While out_valid && !out_ready, out_data, out_round and out_last hold stable.
REQ-029 in_data is never accepted in IDLE or DRAIN; in_valid is ignored there.

Reset
REQ-030 rst = 1 at a clock edge: FSM <= IDLE; key_reg <= 0; round_ctr <= 1; out_valid, out_last, out_round <= 0; out_data <= 0.
REQ-031 Reset takes priority over key_load and accepts in the same cycle; reset mid-run discards the key and any pending output.
REQ-032 In the cycle after reset: in_ready = 0 and busy = 0.

Verification
REQ-033 Reset, then key_load with key_in = 0; accept in_data = 0 -> out_data = 0000000000000000, out_round = 1, out_valid 1 cycle after the accept.
REQ-034 Continue with in_data = 0 for round 2 -> out_data = C000000000000000, out_round = 2.
REQ-035 Hold out_ready = 0 for 5 cycles with in_valid = 1 -> in_ready = 0, outputs stable, round_ctr unchanged; release -> transfers resume with no loss or duplication.
REQ-036 Pulse key_load with a nonzero key during RUN -> the round-key sequence is identical to an uninterrupted run.
REQ-037 Chain with sLayer/pLayer models, key 0, plaintext 0, 32 accepts -> final out_data = 5579C1387B228445, out_last = 1, out_round = 0; then IDLE after drain.
REQ-038 Assert rst at round 10 with out_valid = 1 -> next cycle out_valid = 0, busy = 0; a new key_load restarts at round 1.
